// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: one translation at a time, up to three PTE reads, no TLB.
// A/D bits are checked (optionally) but never written back.
module sv39_ptw #(
   parameter int unsigned PADDR_W  = 56,
   parameter bit          CHECK_AD = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [63:0] req_vaddr_i,
   input  logic [1:0]  req_type_i,
   input  logic [1:0]  priv_i,
   input  logic [63:0] satp_i,
   input  logic        mxr_i,
   input  logic        sum_i,
   input  logic        flush_i,
   output logic        mem_valid_o,
   output logic [63:0] mem_addr_o,
   input  logic        mem_ready_i,
   input  logic [63:0] mem_data_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_paddr_o,
   output logic        resp_fault_o,
   output logic [63:0] resp_cause_o
);

   localparam logic [1:0]  TypeFetch    = 2'd0;
   localparam logic [1:0]  TypeStore    = 2'd2;
   localparam logic [1:0]  PrivU        = 2'd0;
   localparam logic [1:0]  PrivM        = 2'd3;
   localparam logic [3:0]  SatpModeSv39 = 4'd8;
   localparam logic [63:0] PaMask       = (PADDR_W >= 64) ? {64{1'b1}} :
                                          ((64'd1 << PADDR_W) - 64'd1);

   typedef enum logic [1:0] {StIdle, StWalk, StDrain, StResp} state_e;

   state_e      state_q, state_d;
   logic [1:0]  level_q, level_d;
   logic [43:0] a_q, a_d;
   logic [63:0] vaddr_q, vaddr_d;
   logic [1:0]  type_q, type_d;
   logic [1:0]  priv_q, priv_d;
   logic        mxr_q, mxr_d;
   logic        sum_q, sum_d;
   logic [63:0] resp_paddr_q, resp_paddr_d;
   logic        resp_fault_q, resp_fault_d;
   logic [63:0] resp_cause_q, resp_cause_d;

   function automatic logic [63:0] fault_cause(input logic [1:0] t);
      case (t)
         2'd0:    fault_cause = 64'd12;
         2'd2:    fault_cause = 64'd15;
         default: fault_cause = 64'd13;
      endcase
   endfunction

   logic        canonical;
   logic [8:0]  vpn_sel;
   logic [63:0] pte_addr;
   logic [43:0] pte_ppn;
   logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
   logic        pte_bad, pte_leaf, leaf_fault;
   logic        perm_ok, priv_ok, align_ok, ad_ok;
   logic [63:0] leaf_pa;
   logic        unused_bits;

   assign canonical = (&req_vaddr_i[63:38]) || !(|req_vaddr_i[63:38]);

   assign pte_v   = mem_data_i[0];
   assign pte_r   = mem_data_i[1];
   assign pte_w   = mem_data_i[2];
   assign pte_x   = mem_data_i[3];
   assign pte_u   = mem_data_i[4];
   assign pte_a   = mem_data_i[6];
   assign pte_d   = mem_data_i[7];
   assign pte_ppn = mem_data_i[53:10];

   assign unused_bits = ^{mem_data_i[63:54], mem_data_i[9:8], mem_data_i[5], satp_i[59:44]};

   always_comb begin
      vpn_sel = vaddr_q[20:12];
      if (level_q == 2'd2) begin
         vpn_sel = vaddr_q[38:30];
      end else if (level_q == 2'd1) begin
         vpn_sel = vaddr_q[29:21];
      end
      // Full 64-bit sum so a wide ppn never loses its upper bits.
      pte_addr = ({20'b0, a_q} << 12) + {52'b0, vpn_sel, 3'b000};
   end

   always_comb begin
      perm_ok = 1'b0;
      case (type_q)
         TypeFetch: perm_ok = pte_x;
         TypeStore: perm_ok = pte_w;
         default:   perm_ok = pte_r || (mxr_q && pte_x);
      endcase

      priv_ok = 1'b1;
      if (priv_q == PrivU) begin
         priv_ok = pte_u;
      end else if (pte_u) begin
         priv_ok = (type_q != TypeFetch) && sum_q;
      end

      align_ok = 1'b1;
      if (level_q == 2'd2) begin
         align_ok = (pte_ppn[17:0] == 18'd0);
      end else if (level_q == 2'd1) begin
         align_ok = (pte_ppn[8:0] == 9'd0);
      end

      ad_ok      = !CHECK_AD || (pte_a && ((type_q != TypeStore) || pte_d));
      pte_bad    = !pte_v || (!pte_r && pte_w);
      pte_leaf   = pte_r || pte_x;
      leaf_fault = !(perm_ok && priv_ok && align_ok && ad_ok);

      // Superpages take the low VPN fields straight from the virtual address.
      leaf_pa = {8'b0, pte_ppn, vaddr_q[11:0]};
      if (level_q == 2'd1) begin
         leaf_pa[20:12] = vaddr_q[20:12];
      end else if (level_q == 2'd2) begin
         leaf_pa[29:12] = vaddr_q[29:12];
      end
   end

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      a_d          = a_q;
      vaddr_d      = vaddr_q;
      type_d       = type_q;
      priv_d       = priv_q;
      mxr_d        = mxr_q;
      sum_d        = sum_q;
      resp_paddr_d = resp_paddr_q;
      resp_fault_d = resp_fault_q;
      resp_cause_d = resp_cause_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i && !flush_i) begin
               vaddr_d      = req_vaddr_i;
               type_d       = req_type_i;
               priv_d       = priv_i;
               mxr_d        = mxr_i;
               sum_d        = sum_i;
               resp_paddr_d = '0;
               resp_fault_d = 1'b0;
               resp_cause_d = '0;
               // Bare translation has a fixed one-cycle latency, so it goes straight to RESP.
               if ((priv_i == PrivM) || (satp_i[63:60] != SatpModeSv39)) begin
                  state_d      = StResp;
                  resp_paddr_d = req_vaddr_i & PaMask;
               end else if (!canonical) begin
                  state_d      = StResp;
                  resp_fault_d = 1'b1;
                  resp_cause_d = fault_cause(req_type_i);
               end else begin
                  state_d = StWalk;
                  level_d = 2'd2;
                  a_d     = satp_i[43:0];
               end
            end
         end
         StWalk: begin
            if (mem_ready_i) begin
               if (flush_i) begin
                  state_d = StIdle;
               end else if (pte_bad || (!pte_leaf && (level_q == 2'd0)) ||
                            (pte_leaf && leaf_fault)) begin
                  state_d      = StResp;
                  resp_fault_d = 1'b1;
                  resp_cause_d = fault_cause(type_q);
               end else if (!pte_leaf) begin
                  a_d     = pte_ppn;
                  level_d = level_q - 2'd1;
               end else begin
                  state_d      = StResp;
                  resp_paddr_d = leaf_pa & PaMask;
               end
            end else if (flush_i) begin
               state_d = StDrain;
            end
         end
         // Outstanding read must complete on the bus; its data is thrown away.
         StDrain: begin
            if (mem_ready_i) begin
               state_d = StIdle;
            end
         end
         StResp: begin
            if (flush_i || resp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         level_q      <= 2'd0;
         a_q          <= '0;
         vaddr_q      <= '0;
         type_q       <= 2'd0;
         priv_q       <= 2'd0;
         mxr_q        <= 1'b0;
         sum_q        <= 1'b0;
         resp_paddr_q <= '0;
         resp_fault_q <= 1'b0;
         resp_cause_q <= '0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         a_q          <= a_d;
         vaddr_q      <= vaddr_d;
         type_q       <= type_d;
         priv_q       <= priv_d;
         mxr_q        <= mxr_d;
         sum_q        <= sum_d;
         resp_paddr_q <= resp_paddr_d;
         resp_fault_q <= resp_fault_d;
         resp_cause_q <= resp_cause_d;
      end
   end

   always_comb begin
      req_ready_o  = (state_q == StIdle);
      mem_valid_o  = (state_q == StWalk) || (state_q == StDrain);
      mem_addr_o   = mem_valid_o ? pte_addr : '0;
      resp_valid_o = (state_q == StResp) && !flush_i;
      resp_paddr_o = (state_q == StResp) ? resp_paddr_q : '0;
      resp_fault_o = (state_q == StResp) ? resp_fault_q : 1'b0;
      resp_cause_o = (state_q == StResp) ? resp_cause_q : '0;
   end

endmodule

// File: tb/tb_sv39_ptw.sv
// Scoreboard bench for sv39_ptw: directed requests push expected responses and PTE reads;
// independent monitors pop and compare whenever the walker presents a read or a response.
module tb_sv39_ptw;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [63:0] req_vaddr;
   logic [1:0]  req_type, priv;
   logic [63:0] satp;
   logic        mxr, sum, flush;
   logic        mem_valid, mem_ready;
   logic [63:0] mem_addr, mem_data;
   logic        resp_valid, resp_ready, resp_fault;
   logic [63:0] resp_paddr, resp_cause;

   always #5 clk = ~clk;

   sv39_ptw #(.PADDR_W(56), .CHECK_AD(1'b1)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_vaddr_i (req_vaddr),
      .req_type_i  (req_type),
      .priv_i      (priv),
      .satp_i      (satp),
      .mxr_i       (mxr),
      .sum_i       (sum),
      .flush_i     (flush),
      .mem_valid_o (mem_valid),
      .mem_addr_o  (mem_addr),
      .mem_ready_i (mem_ready),
      .mem_data_i  (mem_data),
      .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready),
      .resp_paddr_o(resp_paddr),
      .resp_fault_o(resp_fault),
      .resp_cause_o(resp_cause)
   );

   localparam logic [63:0] Satp = 64'h8000_0000_0008_0000;

   typedef struct {
      logic [63:0] paddr;
      logic        fault;
      logic [63:0] cause;
      int unsigned cyc;
   } resp_t;

   resp_t       exp_q[$];
   logic [63:0] rd_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model: small table of PTEs, with a programmable number of wait cycles.
   logic [63:0] pte_at[4];
   logic [63:0] pte_val[4];
   int unsigned mem_wait = 0;
   int unsigned wait_cnt = 0;

   function automatic logic [63:0] lookup(input logic [63:0] addr);
      for (int i = 0; i < 4; i++) begin
         if (pte_at[i] == addr) return pte_val[i];
      end
      return 64'd0;
   endfunction

   always_comb begin
      mem_ready = mem_valid && (wait_cnt >= mem_wait);
      mem_data  = mem_ready ? lookup(mem_addr) : 64'd0;
   end

   always @(posedge clk) begin
      if (reset || !mem_valid || mem_ready) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   always @(negedge clk) begin
      if (!reset && mem_valid && mem_ready) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: addr 0x%0h, no read expected", mem_addr);
         end else begin
            check64("read_addr", mem_addr, rd_q.pop_front());
         end
      end
   end

   bit          seen = 1'b0;
   int unsigned first_cyc = 0;

   always @(negedge clk) begin
      if (reset) begin
         seen = 1'b0;
      end else if (resp_valid) begin
         if (!seen) begin
            seen      = 1'b1;
            first_cyc = cyc;
         end
         if (resp_ready) begin
            seen = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: paddr 0x%0h fault %0d, no response expected",
                        resp_paddr, resp_fault);
            end else begin
               resp_t e;
               e = exp_q.pop_front();
               check64("resp_paddr", resp_paddr, e.paddr);
               check64("resp_fault", 64'(resp_fault), 64'(e.fault));
               check64("resp_cause", resp_cause, e.cause);
               check64("resp_cycle", 64'(first_cyc), 64'(e.cyc));
            end
         end
      end
   end

   task automatic set_ptes(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
      pte_at[0] = 64'h8000_0008; pte_val[0] = d0;
      pte_at[1] = 64'h8000_1008; pte_val[1] = d1;
      pte_at[2] = 64'h8000_2018; pte_val[2] = d2;
      pte_at[3] = 64'hFFFF_FFFF; pte_val[3] = 64'd0;
   endtask

   // Presents one request at a negedge; returns the accept cycle.
   task automatic start_req(input logic [63:0] va, input logic [1:0] t, input logic [1:0] p,
                            output int unsigned n_acc);
      int unsigned n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: got 0, expected 1");
      end
      req_vaddr = va;
      req_type  = t;
      priv      = p;
      req_valid = 1'b1;
      n_acc     = cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic issue(input logic [63:0] va, input logic [1:0] t, input logic [1:0] p,
                        input int unsigned lat, input logic [63:0] pa, input logic f,
                        input logic [63:0] cs);
      int unsigned n_acc;
      resp_t       e;
      e.paddr = pa;
      e.fault = f;
      e.cause = cs;
      e.cyc   = 0;
      exp_q.push_back(e);
      start_req(va, t, p, n_acc);
      exp_q[exp_q.size() - 1].cyc = n_acc + lat;
   endtask

   task automatic wait_done(input string name);
      int unsigned n = 0;
      while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check64(name, 64'(exp_q.size() + rd_q.size()), 64'd0);
      exp_q.delete();
      rd_q.delete();
   endtask

   task automatic push_walk_reads(input int unsigned cnt);
      rd_q.push_back(64'h8000_0008);
      if (cnt > 1) rd_q.push_back(64'h8000_1008);
      if (cnt > 2) rd_q.push_back(64'h8000_2018);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned n_acc;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_vaddr  = '0;
      req_type   = 2'd0;
      priv       = 2'd1;
      satp       = Satp;
      mxr        = 1'b0;
      sum        = 1'b0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      set_ptes(64'h2000_0401, 64'h2000_0801, 64'h2000_40C7);
      repeat (3) @(negedge clk);
      check64("rst_req_ready", 64'(req_ready), 64'd1);
      check64("rst_mem_valid", 64'(mem_valid), 64'd0);
      check64("rst_resp_valid", 64'(resp_valid), 64'd0);
      check64("rst_resp_fault", 64'(resp_fault), 64'd0);
      check64("rst_mem_addr", mem_addr, 64'd0);
      check64("rst_resp_paddr", resp_paddr, 64'd0);
      check64("rst_resp_cause", resp_cause, 64'd0);
      reset = 1'b0;

      // M-mode bypass
      issue(64'h8000_1234, 2'd1, 2'd3, 1, 64'h8000_1234, 1'b0, 64'd0);
      wait_done("bypass_done");

      // 4KiB walk, S-mode load
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd1, 2'd1, 4, 64'h8001_0123, 1'b0, 64'd0);
      wait_done("walk4k_done");

      // 2MiB superpage with the consumer stalling for a few cycles
      set_ptes(64'h2000_0401, 64'h2008_00C7, 64'd0);
      push_walk_reads(2);
      resp_ready = 1'b0;
      issue(64'h4020_3123, 2'd1, 2'd1, 3, 64'h8020_3123, 1'b0, 64'd0);
      repeat (5) @(negedge clk);
      check64("stall_resp_valid", 64'(resp_valid), 64'd1);
      resp_ready = 1'b1;
      wait_done("super_done");

      // Misaligned superpage
      set_ptes(64'h2000_0401, 64'h2008_04C7, 64'd0);
      push_walk_reads(2);
      issue(64'h4020_3123, 2'd1, 2'd1, 3, 64'd0, 1'b1, 64'd13);
      wait_done("misalign_done");

      // Store to a clean page faults; store to a dirty page succeeds
      set_ptes(64'h2000_0401, 64'h2000_0801, 64'h2000_4047);
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd2, 2'd1, 4, 64'd0, 1'b1, 64'd15);
      wait_done("store_clean_done");
      set_ptes(64'h2000_0401, 64'h2000_0801, 64'h2000_40C7);
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd2, 2'd1, 4, 64'h8001_0123, 1'b0, 64'd0);
      wait_done("store_dirty_done");

      // User page: S-mode fetch faults, U-mode load succeeds
      set_ptes(64'h2000_0401, 64'h2000_0801, 64'h2000_40DB);
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd0, 2'd1, 4, 64'd0, 1'b1, 64'd12);
      wait_done("s_fetch_u_done");
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd1, 2'd0, 4, 64'h8001_0123, 1'b0, 64'd0);
      wait_done("u_load_done");

      // Non-canonical address: no reads, immediate fault
      issue(64'h0000_0080_0000_0000, 2'd1, 2'd1, 1, 64'd0, 1'b1, 64'd13);
      wait_done("noncanon_done");

      // Flush while the first PTE read is stalled
      set_ptes(64'h2000_0401, 64'h2000_0801, 64'h2000_40C7);
      mem_wait = 3;
      rd_q.push_back(64'h8000_0008);
      start_req(64'h4020_3123, 2'd1, 2'd1, n_acc);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check64("flush_mem_valid_held", 64'(mem_valid), 64'd1);
         if (mem_ready || !mem_valid) break;
      end
      @(negedge clk);
      check64("flush_req_ready", 64'(req_ready), 64'd1);
      check64("flush_mem_valid_off", 64'(mem_valid), 64'd0);
      mem_wait = 0;
      wait_done("flush_done");
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd1, 2'd1, 4, 64'h8001_0123, 1'b0, 64'd0);
      wait_done("after_flush_done");

      // Reset in the middle of a stalled walk
      mem_wait = 8;
      start_req(64'h4020_3123, 2'd1, 2'd1, n_acc);
      @(negedge clk);
      check64("midwalk_mem_valid", 64'(mem_valid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check64("midwalk_rst_mem_valid", 64'(mem_valid), 64'd0);
      check64("midwalk_rst_req_ready", 64'(req_ready), 64'd1);
      reset    = 1'b0;
      mem_wait = 0;
      push_walk_reads(3);
      issue(64'h4020_3123, 2'd1, 2'd1, 4, 64'h8001_0123, 1'b0, 64'd0);
      wait_done("after_reset_done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
